// File: rtl/uart_tx_fifo_mod.sv
// Transmit-side UART with an internal byte FIFO.
// Bytes are queued on wr_en and sent as 8N1 frames, LSB first.
// Back-to-back frames follow each other without an idle gap.
// The FIFO memory has a registered read port. The head byte is read one
// cycle ahead, so it is already valid when a frame starts.
module uart_tx_fifo_mod #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_ADDR_W  = 13
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             wr_data,
   input  logic                   wr_en,
   output logic                   tx,
   output logic                   tx_busy,
   output logic [FIFO_ADDR_W:0]   tx_fifo_count,
   output logic                   tx_fifo_full,
   output logic                   tx_fifo_empty,
   output logic                   overflow
);

   localparam int DEPTH  = 2**FIFO_ADDR_W;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0]    BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_ADDR_W:0] COUNT_FULL = {1'b1, {FIFO_ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   // FIFO storage and pointers
   logic [7:0]             mem [DEPTH];
   logic [FIFO_ADDR_W-1:0] wr_ptr_reg;
   logic [FIFO_ADDR_W-1:0] rd_ptr_reg;
   logic [FIFO_ADDR_W-1:0] rd_ptr_next;
   logic [FIFO_ADDR_W:0]   count_reg;
   logic                   overflow_reg;
   logic [7:0]             head_reg;

   // Serialiser state
   state_t                 state_reg;
   logic [BAUD_W-1:0]      baud_reg;
   logic [2:0]             bit_reg;
   logic [7:0]             shift_reg;
   logic                   tx_reg;
   logic                   busy_reg;

   logic                   push;
   logic                   pop;
   logic                   baud_done;

   assign tx_fifo_count = count_reg;
   assign tx_fifo_full  = (count_reg == COUNT_FULL);
   assign tx_fifo_empty = (count_reg == '0);
   assign overflow      = overflow_reg;
   assign tx            = tx_reg;
   assign tx_busy       = busy_reg;

   // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a write
   assign push      = wr_en && !tx_fifo_full;
   assign baud_done = (baud_reg == BAUD_LAST);
   // A byte leaves the FIFO only when a frame starts: either from idle or straight after a stop bit
   assign pop       = !tx_fifo_empty &&
                      ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_done));
   assign rd_ptr_next = pop ? (rd_ptr_reg + 1'b1) : rd_ptr_reg;

   // Memory write plus read-ahead of the next head; a write into the head slot bypasses the array
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
         head_reg <= wr_data;
      end else begin
         head_reg <= mem[rd_ptr_next];
      end
   end

   // Pointer, occupancy and sticky overflow bookkeeping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         rd_ptr_reg <= rd_ptr_next;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (wr_en && tx_fifo_full) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Frame serialiser: start bit, eight data bits LSB first, stop bit; outputs registered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               tx_reg   <= 1'b1;
               busy_reg <= 1'b0;
               baud_reg <= '0;
               if (pop) begin
                  shift_reg <= head_reg;
                  tx_reg    <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (baud_done) begin
                  baud_reg  <= '0;
                  bit_reg   <= '0;
                  tx_reg    <= shift_reg[0];
                  state_reg <= ST_DATA;
               end else begin
                  baud_reg <= baud_reg + 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_done) begin
                  baud_reg <= '0;
                  if (bit_reg == 3'd7) begin
                     tx_reg    <= 1'b1;
                     state_reg <= ST_STOP;
                  end else begin
                     bit_reg   <= bit_reg + 1'b1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx_reg    <= shift_reg[1];
                  end
               end else begin
                  baud_reg <= baud_reg + 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_done) begin
                  baud_reg <= '0;
                  if (pop) begin
                     shift_reg <= head_reg;
                     tx_reg    <= 1'b0;
                     state_reg <= ST_START;
                  end else begin
                     busy_reg  <= 1'b0;
                     state_reg <= ST_IDLE;
                  end
               end else begin
                  baud_reg <= baud_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_mod.sv
// Bench for uart_tx_fifo_mod with a small baud divisor and a 4-deep FIFO.
// Accepted bytes go into a queue. A line receiver decodes each frame and
// compares the decoded byte against the front of that queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo_mod;

   localparam int CPB = 4;
   localparam int AW  = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_en = 1'b0;
   logic          tx;
   logic          tx_busy;
   logic [AW:0]   tx_fifo_count;
   logic          tx_fifo_full;
   logic          tx_fifo_empty;
   logic          overflow;

   int            n_checks = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            rx_frames = 0;
   logic [7:0]    exp_q[$];
   int            start_q[$];

   uart_tx_fifo_mod #(
      .CLKS_PER_BIT (CPB),
      .FIFO_ADDR_W  (AW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_data       (wr_data),
      .wr_en         (wr_en),
      .tx            (tx),
      .tx_busy       (tx_busy),
      .tx_fifo_count (tx_fifo_count),
      .tx_fifo_full  (tx_fifo_full),
      .tx_fifo_empty (tx_fifo_empty),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Drive one write strobe at a negedge; returns at the following negedge
   task automatic write_byte(input logic [7:0] d, input bit accept);
      wr_data = d;
      wr_en   = 1'b1;
      if (accept) exp_q.push_back(d);
      $display("wr 0x%02h accept=%0d at cycle %0d", d, accept, cyc);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tx_busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, (n < 2000), 1);
      repeat (5) @(negedge clk);
   endtask

   // Line receiver: samples mid-bit on negedges and scores each complete frame
   initial begin : monitor
      logic [7:0] b;
      logic [7:0] exp_b;
      logic       st_ok;
      logic       sp_ok;
      logic       clean;
      int         t0;
      wait (reset === 1'b1);
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            t0 = cyc;
            clean = 1'b1;
            repeat (2) @(negedge clk);
            st_ok = (tx === 1'b0);
            if (reset !== 1'b1) clean = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
               if (reset !== 1'b1) clean = 1'b0;
            end
            repeat (CPB) @(negedge clk);
            sp_ok = (tx === 1'b1);
            if (reset !== 1'b1) clean = 1'b0;
            if (clean) begin
               rx_frames++;
               start_q.push_back(t0);
               exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
               $display("rx 0x%02h start cycle %0d expected 0x%02h", b, t0, exp_b);
               check("start_bit", st_ok, 1);
               check("stop_bit", sp_ok, 1);
               check("rx_byte", {24'd0, b}, {24'd0, exp_b});
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int lows;
      int frames0;
      int exp_cnt [6];
      exp_cnt = '{1, 1, 2, 3, 4, 4};

      // 1: reset state and quiet line
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_count", tx_fifo_count, 0);
      check("rst_empty", tx_fifo_empty, 1);
      check("rst_full", tx_fifo_full, 0);
      check("rst_overflow", overflow, 0);
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("idle_tx_low_cycles", lows, 0);

      // 2: single byte, latency and frame length
      write_byte(8'hA5, 1);
      check("lat_tx_before", tx, 1);
      check("lat_count", tx_fifo_count, 1);
      @(negedge clk);
      check("lat_tx_start", tx, 0);
      check("lat_busy", tx_busy, 1);
      check("lat_count_popped", tx_fifo_count, 0);
      n = 0;
      while (tx_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("frame_len", n, 40);
      wait_drain("drain_single");
      check("single_count_end", tx_fifo_count, 0);

      // 3: three contiguous frames
      start_q.delete();
      write_byte(8'h00, 1);
      write_byte(8'hFF, 1);
      write_byte(8'h55, 1);
      wait_drain("drain_three");
      check("three_frames", start_q.size(), 3);
      if (start_q.size() == 3) begin
         check("gap_0_1", start_q[1] - start_q[0], 40);
         check("gap_1_2", start_q[2] - start_q[1], 40);
      end

      // 4: fill to full, drop one, sticky overflow
      for (int i = 0; i < 6; i++) begin
         write_byte(8'h10 + 8'(i), (i < 5));
         check($sformatf("fill_count_%0d", i), tx_fifo_count, exp_cnt[i]);
         check($sformatf("fill_full_%0d", i), tx_fifo_full, (i >= 4));
         check($sformatf("fill_ovf_%0d", i), overflow, (i == 5));
      end
      wait_drain("drain_fill");
      check("ovf_sticky", overflow, 1);
      check("fill_empty_end", tx_fifo_empty, 1);

      // 5: asynchronous reset in the middle of a data bit
      write_byte(8'h3C, 1);
      write_byte(8'hC3, 1);
      write_byte(8'h5A, 1);
      repeat (15) @(negedge clk);
      check("pre_rst_busy", tx_busy, 1);
      check("pre_rst_count", tx_fifo_count, 2);
      #2;
      reset = 1'b0;
      #1;
      check("arst_tx", tx, 1);
      check("arst_count", tx_fifo_count, 0);
      check("arst_busy", tx_busy, 0);
      check("arst_ovf", overflow, 0);
      exp_q.delete();
      repeat (5) @(negedge clk);
      reset = 1'b1;
      frames0 = rx_frames;
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("post_rst_tx_low", lows, 0);
      check("post_rst_frames", rx_frames - frames0, 0);

      // 6: write while full on the stop-to-start edge is dropped
      write_byte(8'h61, 1);
      write_byte(8'h62, 1);
      write_byte(8'h63, 1);
      write_byte(8'h64, 1);
      write_byte(8'h65, 1);
      repeat (36) @(negedge clk);
      check("edge_pre_count", tx_fifo_count, 4);
      check("edge_pre_full", tx_fifo_full, 1);
      check("edge_pre_ovf", overflow, 0);
      wr_data = 8'hEE;
      wr_en   = 1'b1;
      $display("wr 0xee accept=0 at cycle %0d", cyc);
      @(negedge clk);
      wr_en = 1'b0;
      check("edge_count", tx_fifo_count, 3);
      check("edge_ovf", overflow, 1);
      check("edge_tx_start", tx, 0);
      wait_drain("drain_edge");
      check("edge_empty_end", tx_fifo_empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
